// File: rtl/ysyx_22050019_lsu_pkg.sv
// Shared encodings for the LSU: request opcode, access size, FSM state and
// bus response codes, plus a helper that gives the low-address alignment mask.
package ysyx_22050019_lsu_pkg;

   typedef enum logic [1:0] {
      OP_PASS  = 2'b00,
      OP_LOAD  = 2'b01,
      OP_STORE = 2'b10,
      OP_RSVD  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_D = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RADDR = 3'd1,
      ST_RDATA = 3'd2,
      ST_WREQ  = 3'd3,
      ST_WRESP = 3'd4,
      ST_RESP  = 3'd5
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Low address bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] size_mask(input size_e sz);
      case (sz)
         SZ_B:    return 3'b000;
         SZ_H:    return 3'b001;
         SZ_W:    return 3'b011;
         default: return 3'b111;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_22050019_lsu_axi_if.sv
// Bundle of the EXU request, WBU writeback and AXI-lite style bus channels.
// master = LSU side, slave = environment (EXU/WBU/interconnect) side.
interface ysyx_22050019_lsu_axi_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int RD_W   = 5
);
   logic              in_valid, in_ready;
   logic [1:0]        in_op, in_size;
   logic              in_signed;
   logic [ADDR_W-1:0] in_addr;
   logic [DATA_W-1:0] in_wdata;
   logic [RD_W-1:0]   in_rd;

   logic              out_valid, out_ready, out_wen, out_err;
   logic [RD_W-1:0]   out_rd;
   logic [DATA_W-1:0] out_wdata;

   logic              ar_valid, ar_ready;
   logic [ADDR_W-1:0] ar_addr;
   logic              r_valid, r_ready;
   logic [DATA_W-1:0] r_data;
   logic [1:0]        r_resp;
   logic              aw_valid, aw_ready;
   logic [ADDR_W-1:0] aw_addr;
   logic              w_valid, w_ready;
   logic [DATA_W-1:0] w_data;
   logic [DATA_W/8-1:0] w_strb;
   logic              b_valid, b_ready;
   logic [1:0]        b_resp;

   modport master (
      input  in_valid, in_op, in_size, in_signed, in_addr, in_wdata, in_rd,
      output in_ready,
      output out_valid, out_wen, out_err, out_rd, out_wdata,
      input  out_ready,
      output ar_valid, ar_addr, input ar_ready,
      input  r_valid, r_data, r_resp, output r_ready,
      output aw_valid, aw_addr, input aw_ready,
      output w_valid, w_data, w_strb, input w_ready,
      input  b_valid, b_resp, output b_ready
   );

   modport slave (
      output in_valid, in_op, in_size, in_signed, in_addr, in_wdata, in_rd,
      input  in_ready,
      input  out_valid, out_wen, out_err, out_rd, out_wdata,
      output out_ready,
      input  ar_valid, ar_addr, output ar_ready,
      output r_valid, r_data, r_resp, input r_ready,
      input  aw_valid, aw_addr, output aw_ready,
      input  w_valid, w_data, w_strb, output w_ready,
      output b_valid, b_resp, input b_ready
   );
endinterface

// File: rtl/ysyx_22050019_lsu_align.sv
// Combinational lane handling: load extract/sign-extend and store
// data shift / byte-strobe generation from the in-bus byte offset.
module ysyx_22050019_lsu_align #(
   parameter int DATA_W = 64,
   parameter int OFF_W  = $clog2(DATA_W/8),
   parameter int STRB_W = DATA_W/8
) (
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [OFF_W-1:0]  offset,
   input  logic [DATA_W-1:0] r_data,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] ld_data,
   output logic [DATA_W-1:0] st_data,
   output logic [STRB_W-1:0] st_strb
);
   logic [DATA_W-1:0] shifted;
   logic [7:0]        nbits;
   logic              sign_bit;
   logic [7:0]        strb_base;

   // Bring the addressed lane down to bit 0 and pick its width / sign bit.
   always_comb begin
      shifted = r_data >> {offset, 3'b000};
      case (size)
         2'd0:    begin nbits = 8'd8;  sign_bit = shifted[7];  end
         2'd1:    begin nbits = 8'd16; sign_bit = shifted[15]; end
         2'd2:    begin nbits = 8'd32; sign_bit = shifted[31]; end
         default: begin nbits = 8'd64; sign_bit = 1'b0;        end
      endcase
   end

   // Bits inside the access width come from the lane, the rest are extension.
   for (genvar gi = 0; gi < DATA_W; gi++) begin : g_ext
      assign ld_data[gi] = (8'(gi) < nbits) ? shifted[gi] : (sign_ext & sign_bit);
   end

   // Store data and byte strobes move up to the addressed lane.
   always_comb begin
      case (size)
         2'd0:    strb_base = 8'h01;
         2'd1:    strb_base = 8'h03;
         2'd2:    strb_base = 8'h0F;
         default: strb_base = 8'hFF;
      endcase
      st_data = wdata << {offset, 3'b000};
      st_strb = strb_base[STRB_W-1:0] << offset;
   end
endmodule

// File: rtl/ysyx_22050019_lsu_axi.sv
// Load/store unit: accepts one EXU request at a time, performs the bus
// read or write (or none for pass-through / misaligned) and hands a
// registered writeback payload to the WBU.
module ysyx_22050019_lsu_axi
   import ysyx_22050019_lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int RD_W   = 5
) (
   input  logic clk,
   input  logic rst_n,
   ysyx_22050019_lsu_axi_if.master bus
);
   localparam int OFF_W  = $clog2(DATA_W/8);
   localparam int STRB_W = DATA_W/8;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   size_e             size_q, size_d;
   logic              signed_q, signed_d;
   logic [RD_W-1:0]   rd_q, rd_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              aw_pend_q, aw_pend_d;
   logic              w_pend_q, w_pend_d;
   logic              out_wen_q, out_wen_d;
   logic              out_err_q, out_err_d;
   logic [DATA_W-1:0] out_wdata_q, out_wdata_d;

   logic [DATA_W-1:0] ld_data, st_data;
   logic [STRB_W-1:0] st_strb;
   logic [ADDR_W-1:0] bus_addr;
   size_e             in_size;
   op_e               in_op;
   logic              in_misal;

   assign in_size  = size_e'(bus.in_size);
   assign in_op    = op_e'(bus.in_op);
   // A 64-bit access cannot be carried on a 32-bit bus in one beat.
   assign in_misal = ((bus.in_addr[2:0] & size_mask(in_size)) != 3'b000) ||
                     (in_size == SZ_D && DATA_W == 32);
   assign bus_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

   ysyx_22050019_lsu_align #(.DATA_W(DATA_W)) u_align (
      .size     (size_q),
      .sign_ext (signed_q),
      .offset   (addr_q[OFF_W-1:0]),
      .r_data   (bus.r_data),
      .wdata    (wdata_q),
      .ld_data  (ld_data),
      .st_data  (st_data),
      .st_strb  (st_strb)
   );

   // State and request/response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         size_q      <= SZ_B;
         signed_q    <= 1'b0;
         rd_q        <= '0;
         wdata_q     <= '0;
         aw_pend_q   <= 1'b0;
         w_pend_q    <= 1'b0;
         out_wen_q   <= 1'b0;
         out_err_q   <= 1'b0;
         out_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         rd_q        <= rd_d;
         wdata_q     <= wdata_d;
         aw_pend_q   <= aw_pend_d;
         w_pend_q    <= w_pend_d;
         out_wen_q   <= out_wen_d;
         out_err_q   <= out_err_d;
         out_wdata_q <= out_wdata_d;
      end
   end

   // Next-state and payload capture; every bus input is only looked at in
   // the state that consumes it.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      size_d      = size_q;
      signed_d    = signed_q;
      rd_d        = rd_q;
      wdata_d     = wdata_q;
      aw_pend_d   = aw_pend_q;
      w_pend_d    = w_pend_q;
      out_wen_d   = out_wen_q;
      out_err_d   = out_err_q;
      out_wdata_d = out_wdata_q;
      case (state_q)
         ST_IDLE: if (bus.in_valid) begin
            addr_d   = bus.in_addr;
            size_d   = in_size;
            signed_d = bus.in_signed;
            rd_d     = bus.in_rd;
            wdata_d  = bus.in_wdata;
            if ((in_op == OP_LOAD || in_op == OP_STORE) && in_misal) begin
               state_d     = ST_RESP;
               out_wen_d   = 1'b0;
               out_err_d   = 1'b1;
               out_wdata_d = '0;
            end else if (in_op == OP_LOAD) begin
               state_d = ST_RADDR;
            end else if (in_op == OP_STORE) begin
               state_d   = ST_WREQ;
               aw_pend_d = 1'b1;
               w_pend_d  = 1'b1;
            end else begin
               state_d     = ST_RESP;
               out_wen_d   = (bus.in_rd != '0);
               out_err_d   = 1'b0;
               out_wdata_d = DATA_W'(bus.in_addr);
            end
         end
         ST_RADDR: if (bus.ar_ready) state_d = ST_RADDR == state_q ? ST_RDATA : state_q;
         ST_RDATA: if (bus.r_valid) begin
            state_d     = ST_RESP;
            out_err_d   = (bus.r_resp != RESP_OKAY);
            out_wen_d   = (bus.r_resp == RESP_OKAY) && (rd_q != '0);
            out_wdata_d = (bus.r_resp == RESP_OKAY) ? ld_data : '0;
         end
         ST_WREQ: begin
            if (aw_pend_q && bus.aw_ready) aw_pend_d = 1'b0;
            if (w_pend_q && bus.w_ready)   w_pend_d  = 1'b0;
            if (!aw_pend_d && !w_pend_d)   state_d   = ST_WRESP;
         end
         ST_WRESP: if (bus.b_valid) begin
            state_d     = ST_RESP;
            out_wen_d   = 1'b0;
            out_err_d   = (bus.b_resp != RESP_OKAY);
            out_wdata_d = '0;
         end
         ST_RESP: if (bus.out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are pure functions of registered state, so no valid depends on
   // its own ready, and address/data are zero outside their channel state.
   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.ar_valid  = (state_q == ST_RADDR);
   assign bus.ar_addr   = (state_q == ST_RADDR) ? bus_addr : '0;
   assign bus.r_ready   = (state_q == ST_RDATA);
   assign bus.aw_valid  = (state_q == ST_WREQ) && aw_pend_q;
   assign bus.aw_addr   = (state_q == ST_WREQ) ? bus_addr : '0;
   assign bus.w_valid   = (state_q == ST_WREQ) && w_pend_q;
   assign bus.w_data    = (state_q == ST_WREQ) ? st_data : '0;
   assign bus.w_strb    = (state_q == ST_WREQ) ? st_strb : '0;
   assign bus.b_ready   = (state_q == ST_WRESP);
   assign bus.out_valid = (state_q == ST_RESP);
   assign bus.out_wen   = out_wen_q;
   assign bus.out_err   = out_err_q;
   assign bus.out_rd    = rd_q;
   assign bus.out_wdata = out_wdata_q;
endmodule

// File: tb/tb_ysyx_22050019_lsu_axi.sv
// Scoreboard bench for the LSU: expected writebacks are queued when a
// request is driven and compared when the DUT presents out_valid.
module tb_ysyx_22050019_lsu_axi;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   accept_cyc = 0;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      string       name;
      logic        wen;
      logic [4:0]  rd;
      logic [63:0] wdata;
      logic        chk_data;
      logic        err;
      int          lat;
      bit          no_bus;
   } exp_t;
   exp_t sb[$];

   ysyx_22050019_lsu_axi_if #(.ADDR_W(32), .DATA_W(64), .RD_W(5)) bus ();

   ysyx_22050019_lsu_axi #(.ADDR_W(32), .DATA_W(64), .RD_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish before 500us");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model_load(input logic [63:0] data, input logic [2:0] off,
                                              input logic [1:0] sz, input logic sx);
      logic [63:0] v;
      v = data >> (8 * off);
      case (sz)
         2'd0: return sx ? {{56{v[7]}}, v[7:0]}   : {56'd0, v[7:0]};
         2'd1: return sx ? {{48{v[15]}}, v[15:0]} : {48'd0, v[15:0]};
         2'd2: return sx ? {{32{v[31]}}, v[31:0]} : {32'd0, v[31:0]};
         default: return v;
      endcase
   endfunction

   task automatic send_req(input logic [1:0] op, input logic [1:0] sz, input logic sx,
                           input logic [31:0] addr, input logic [63:0] wdata, input logic [4:0] rd);
      check_eq("in_ready_idle", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1; bus.in_op = op; bus.in_size = sz; bus.in_signed = sx;
      bus.in_addr = addr; bus.in_wdata = wdata; bus.in_rd = rd;
      @(negedge clk);
      accept_cyc = cyc;
      bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_addr = '0; bus.in_wdata = '0;
   endtask

   task automatic serve_read(input logic [31:0] exp_addr, input logic [63:0] data,
                             input logic [1:0] resp, input int dly);
      int n = 0;
      while (!bus.ar_valid && n < 20) begin @(negedge clk); n++; end
      check_eq("ar_valid", 64'(bus.ar_valid), 64'd1);
      for (int k = 0; k < dly; k++) begin
         check_eq("ar_valid_held", 64'(bus.ar_valid), 64'd1);
         check_eq("ar_addr_held", 64'(bus.ar_addr), 64'(exp_addr));
         @(negedge clk);
      end
      check_eq("ar_addr", 64'(bus.ar_addr), 64'(exp_addr));
      bus.ar_ready = 1'b1;
      @(negedge clk);
      bus.ar_ready = 1'b0;
      n = 0;
      while (!bus.r_ready && n < 20) begin @(negedge clk); n++; end
      check_eq("r_ready", 64'(bus.r_ready), 64'd1);
      bus.r_valid = 1'b1; bus.r_data = data; bus.r_resp = resp;
      @(negedge clk);
      bus.r_valid = 1'b0; bus.r_data = '0; bus.r_resp = 2'b00;
   endtask

   task automatic serve_write(input logic [31:0] exp_addr, input logic [63:0] exp_data,
                              input logic [7:0] exp_strb, input int aw_dly, input int w_dly,
                              input logic [1:0] resp);
      int n = 0;
      bit aw_done = 0;
      bit w_done = 0;
      while (!(bus.aw_valid && bus.w_valid) && n < 20) begin @(negedge clk); n++; end
      check_eq("aw_w_together", 64'(bus.aw_valid && bus.w_valid), 64'd1);
      check_eq("aw_addr", 64'(bus.aw_addr), 64'(exp_addr));
      check_eq("w_data", bus.w_data, exp_data);
      check_eq("w_strb", 64'(bus.w_strb), 64'(exp_strb));
      for (int k = 0; k < 10 && !(aw_done && w_done); k++) begin
         check_eq("aw_valid_phase", 64'(bus.aw_valid), 64'(!aw_done));
         check_eq("w_valid_phase", 64'(bus.w_valid), 64'(!w_done));
         bus.aw_ready = (k == aw_dly);
         bus.w_ready  = (k == w_dly);
         @(negedge clk);
         if (k == aw_dly) aw_done = 1;
         if (k == w_dly)  w_done = 1;
         bus.aw_ready = 1'b0; bus.w_ready = 1'b0;
      end
      n = 0;
      while (!bus.b_ready && n < 20) begin @(negedge clk); n++; end
      check_eq("b_ready", 64'(bus.b_ready), 64'd1);
      bus.b_valid = 1'b1; bus.b_resp = resp;
      @(negedge clk);
      bus.b_valid = 1'b0; bus.b_resp = 2'b00;
   endtask

   task automatic get_resp(input int hold);
      int n = 0;
      exp_t e;
      if (sb.size() == 0) begin
         check_eq("sb_empty", 64'd0, 64'd1);
         return;
      end
      e = sb.pop_front();
      while (!bus.out_valid && n < 50) begin
         if (e.no_bus) check_eq("no_bus_act", 64'(bus.ar_valid || bus.aw_valid || bus.w_valid), 64'd0);
         @(negedge clk); n++;
      end
      check_eq("out_valid_seen", 64'(bus.out_valid), 64'd1);
      if (e.no_bus) check_eq("no_bus_act", 64'(bus.ar_valid || bus.aw_valid || bus.w_valid), 64'd0);
      if (e.lat != 0) check_eq("latency", 64'(cyc - accept_cyc + 1), 64'(e.lat));
      check_eq("out_wen", 64'(bus.out_wen), 64'(e.wen));
      check_eq("out_err", 64'(bus.out_err), 64'(e.err));
      check_eq("out_rd", 64'(bus.out_rd), 64'(e.rd));
      if (e.chk_data) check_eq("out_wdata", bus.out_wdata, e.wdata);
      $display("txn %-14s wen=%0d rd=%0d wdata=%h err=%0d lat=%0d", e.name,
               bus.out_wen, bus.out_rd, bus.out_wdata, bus.out_err, cyc - accept_cyc + 1);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check_eq("hold_valid", 64'(bus.out_valid), 64'd1);
         check_eq("hold_in_ready", 64'(bus.in_ready), 64'd0);
         check_eq("hold_wen", 64'(bus.out_wen), 64'(e.wen));
         check_eq("hold_err", 64'(bus.out_err), 64'(e.err));
         if (e.chk_data) check_eq("hold_wdata", bus.out_wdata, e.wdata);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_eq("back_idle", 64'(bus.in_ready), 64'd1);
      check_eq("out_valid_drop", 64'(bus.out_valid), 64'd0);
   endtask

   task automatic do_pass(input string name, input logic [1:0] op, input logic [31:0] addr,
                          input logic [4:0] rd, input int hold);
      exp_t e;
      e.name = name; e.wen = (rd != 0); e.rd = rd; e.wdata = 64'(addr); e.chk_data = 1;
      e.err = 0; e.lat = 1; e.no_bus = 1;
      sb.push_back(e);
      send_req(op, 2'b00, 1'b0, addr, 64'd0, rd);
      get_resp(hold);
   endtask

   task automatic do_load(input string name, input logic [31:0] addr, input logic [1:0] sz,
                          input logic sx, input logic [4:0] rd, input logic [63:0] rdata,
                          input logic [1:0] resp, input int ar_dly, input int hold);
      exp_t e;
      e.name = name; e.err = (resp != 2'b00); e.wen = !e.err && (rd != 0); e.rd = rd;
      e.wdata = model_load(rdata, addr[2:0], sz, sx); e.chk_data = !e.err;
      e.lat = (ar_dly == 0) ? 3 : 0; e.no_bus = 0;
      sb.push_back(e);
      send_req(2'b01, sz, sx, addr, 64'd0, rd);
      serve_read({addr[31:3], 3'b000}, rdata, resp, ar_dly);
      get_resp(hold);
   endtask

   task automatic do_store(input string name, input logic [31:0] addr, input logic [1:0] sz,
                           input logic [63:0] wdata, input int aw_dly, input int w_dly,
                           input logic [1:0] resp);
      exp_t e;
      logic [7:0] strb_base;
      strb_base = 8'((16'd1 << (1 << sz)) - 16'd1);
      e.name = name; e.err = (resp != 2'b00); e.wen = 0; e.rd = 5'd7; e.wdata = '0;
      e.chk_data = 0; e.lat = (aw_dly == 0 && w_dly == 0) ? 3 : 0; e.no_bus = 0;
      sb.push_back(e);
      send_req(2'b10, sz, 1'b0, addr, wdata, 5'd7);
      serve_write({addr[31:3], 3'b000}, wdata << (8 * addr[2:0]),
                  strb_base << addr[2:0], aw_dly, w_dly, resp);
      get_resp(0);
   endtask

   task automatic do_misal(input string name, input logic [1:0] op, input logic [31:0] addr,
                           input logic [1:0] sz);
      exp_t e;
      e.name = name; e.wen = 0; e.err = 1; e.rd = 5'd9; e.wdata = '0; e.chk_data = 0;
      e.lat = 1; e.no_bus = 1;
      sb.push_back(e);
      send_req(op, sz, 1'b0, addr, 64'hFFFF, 5'd9);
      get_resp(0);
   endtask

   initial begin
      bus.in_valid = 0; bus.in_op = 0; bus.in_size = 0; bus.in_signed = 0; bus.in_addr = 0;
      bus.in_wdata = 0; bus.in_rd = 0; bus.out_ready = 0; bus.ar_ready = 0; bus.r_valid = 0;
      bus.r_data = 0; bus.r_resp = 0; bus.aw_ready = 0; bus.w_ready = 0; bus.b_valid = 0;
      bus.b_resp = 0;
      repeat (2) @(negedge clk);
      check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check_eq("rst_valids", 64'({bus.out_valid, bus.ar_valid, bus.aw_valid, bus.w_valid}), 64'd0);
      check_eq("rst_readies", 64'({bus.r_ready, bus.b_ready}), 64'd0);
      check_eq("rst_wen_err", 64'({bus.out_wen, bus.out_err}), 64'd0);
      check_eq("rst_addr", 64'(bus.ar_addr | bus.aw_addr), 64'd0);
      check_eq("rst_data", bus.w_data | bus.out_wdata | 64'(bus.w_strb), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_pass("pass", 2'b00, 32'h1234, 5'd5, 0);
      do_pass("pass_rsvd_rd0", 2'b11, 32'hDEAD, 5'd0, 2);
      do_load("lb_signed", 32'h8003, 2'd0, 1'b1, 5'd3, 64'h00000000_80000000, 2'b00, 0, 0);
      do_load("lbu", 32'h8003, 2'd0, 1'b0, 5'd3, 64'h00000000_80000000, 2'b00, 0, 0);
      do_load("lh_signed", 32'h8006, 2'd1, 1'b1, 5'd4, 64'h8123_0000_0000_0000, 2'b00, 2, 0);
      do_load("lwu", 32'h8004, 2'd2, 1'b0, 5'd6, 64'hCAFEBABE_00000000, 2'b00, 0, 0);
      do_load("ld", 32'h8008, 2'd3, 1'b1, 5'd8, 64'h0123_4567_89AB_CDEF, 2'b00, 1, 0);
      do_load("lw_signed_rd0", 32'h8000, 2'd2, 1'b1, 5'd0, 64'h0_F0000000, 2'b00, 0, 0);
      do_store("sh_aw_first", 32'h8006, 2'd1, 64'hBEEF, 0, 2, 2'b00);
      do_store("sh_w_first", 32'h8006, 2'd1, 64'hBEEF, 3, 1, 2'b00);
      do_store("sh_same", 32'h8006, 2'd1, 64'hBEEF, 0, 0, 2'b00);
      do_store("sb", 32'h8001, 2'd0, 64'h5A, 0, 0, 2'b00);
      do_store("sw", 32'h8004, 2'd2, 64'h1122_3344, 1, 1, 2'b00);
      do_misal("misal_lw", 2'b01, 32'h8002, 2'd2);
      do_misal("misal_sd", 2'b10, 32'h8004, 2'd3);
      do_load("lw_slverr", 32'h8000, 2'd2, 1'b0, 5'd2, 64'h1, 2'b10, 0, 4);
      do_store("sd_slverr", 32'h8000, 2'd3, 64'h1, 0, 0, 2'b10);

      // Reset while waiting for read data: everything must drop at once.
      send_req(2'b01, 2'd3, 1'b0, 32'h8010, 64'd0, 5'd1);
      bus.ar_ready = 1'b1;
      @(negedge clk);
      bus.ar_ready = 1'b0;
      check_eq("in_rdata", 64'(bus.r_ready), 64'd1);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
      check_eq("mid_rst_valids", 64'({bus.out_valid, bus.ar_valid, bus.aw_valid, bus.w_valid}), 64'd0);
      check_eq("mid_rst_readies", 64'({bus.r_ready, bus.b_ready}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_idle", 64'(bus.in_ready), 64'd1);
      check_eq("post_rst_no_out", 64'(bus.out_valid), 64'd0);
      $display("txn %-14s in_ready=%0d out_valid=%0d", "reset_rdata", bus.in_ready, bus.out_valid);
      do_pass("pass_after_rst", 2'b00, 32'h55AA, 5'd31, 0);

      check_eq("sb_drained", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ysyx_22050019_lsu_axi.md
YSYX_22050019_LSU_AXI -- requirements
Module: ysyx_22050019_lsu_axi

Interface
REQ-001 The block SHALL be parametrised as follows.
- ADDR_W, default 32: bus and effective-address width.
- DATA_W, default 64: bus data width; legal values are 32 and 64.
- RD_W, default 5: destination register index width.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid/in_ready  in/out  1/1  request handshake from EXU.
- in_op  in  2  00 pass-through, 01 load, 10 store; 11 reserved, treated as pass-through.
- in_size  in  2  00 byte, 01 half, 10 word, 11 double.
- in_signed  in  1  load sign-extend enable.
- in_addr  in  ADDR_W  ALU result: effective address, or pass-through value.
- in_wdata  in  DATA_W  store data.
- in_rd  in  RD_W  destination register.
- out_valid/out_ready  out/in  1/1  writeback handshake to WBU.
- out_wen, out_rd, out_wdata, out_err  out  1/RD_W/DATA_W/1  writeback payload.
- ar_valid/ar_ready/ar_addr  out/in/out  1/1/ADDR_W  read-address channel.
- r_valid/r_ready/r_data/r_resp  in/out/in/in  1/1/DATA_W/2  read-data channel.
- aw_valid/aw_ready/aw_addr  out/in/out  1/1/ADDR_W  write-address channel.
- w_valid/w_ready/w_data/w_strb  out/in/out/out  1/1/DATA_W/DATA_W/8  write-data channel.
- b_valid/b_ready/b_resp  in/out/in  1/1/2  write-response channel.

Function
REQ-003 The FSM SHALL have states IDLE, RADDR, RDATA, WREQ, WRESP and RESP; in_ready SHALL be 1 only in IDLE; the request SHALL be latched on in_valid&&in_ready.
REQ-004 Pass-through: IDLE->RESP with out_wdata=zero-extended in_addr, out_wen=(in_rd!=0), out_err=0, and no bus activity.
REQ-005 Misaligned access, meaning addr not a multiple of 2^size or size=11 with DATA_W=32: IDLE->RESP with out_err=1, out_wen=0, and no bus activity.
REQ-006 Load: IDLE->RADDR; ar_addr SHALL be addr aligned down to DATA_W/8; ar_valid SHALL be held until ar_ready, then RDATA; r_ready SHALL be 1 in RDATA.
REQ-007 On r_valid, lane = r_data >> (8*addr offset), truncated to the size and then sign- or zero-extended per in_signed; r_resp!=0 SHALL give out_err=1 and out_wen=0; otherwise out_wen=(in_rd!=0); the FSM SHALL then go to RESP.
REQ-008 Store: in WREQ, aw_valid and w_valid SHALL assert in the same cycle; each SHALL drop independently after its own handshake, and the FSM SHALL go to WRESP once both have completed, in either order or in the same cycle.
REQ-009 w_data SHALL be in_wdata << (8*offset); w_strb SHALL be ((1<<2^size)-1) << offset.
REQ-010 b_ready SHALL be 1 in WRESP; on b_valid the FSM SHALL go to RESP with out_wen=0 and out_err=(b_resp!=0).
REQ-011 In RESP, out_valid=1 and the payload SHALL be stable until out_ready; on the handshake the FSM SHALL return to IDLE; the earliest next acceptance is the following cycle.
REQ-012 No valid output SHALL depend combinationally on its ready; addresses and data SHALL be stable while their valid is high.
REQ-013 Minimum latencies from acceptance to out_valid: pass-through/misaligned 1 cycle; load 3 cycles with 0-wait ready/valid; store 3 cycles.
REQ-014 Ready or valid inputs arriving in states that do not consume them SHALL be ignored.

Reset
REQ-015 While rst_n=0, the FSM SHALL be in IDLE and all valid outputs, out_wen, out_err, r_ready and b_ready SHALL be 0; data/address outputs SHALL be 0; in_ready SHALL be 1.
REQ-016 Reset asserted mid-transaction SHALL abandon it immediately, without completing the handshake; the interconnect is reset in the same domain.

Structure
REQ-017 Package ysyx_22050019_lsu_pkg SHALL hold the op, size, state and resp encodings.
REQ-018 Sub-module ysyx_22050019_lsu_align (combinational) SHALL perform load extract/extend and store shift/strobe generation.

Verification
REQ-019 Pass-through: op=00, addr=0x1234, rd=5 -> out_valid on the next cycle, out_wdata=0x1234, out_wen=1.
REQ-020 Signed byte load: addr=0x8003, r_data=0x00000000_80000000 (lane 3 = 0x80) -> out_wdata=0xFFFF_FFFF_FFFF_FF80; with in_signed=0 -> 0x80.
REQ-021 Store half: addr=0x8006, wdata=0xBEEF -> aw_addr=0x8000, w_data=0xBEEF<<48, w_strb=0xC0; run with aw_ready before w_ready, after it, and in the same cycle.
REQ-022 Misaligned word load: addr=0x8002 -> out_err=1, out_wen=0, ar_valid never asserted.
REQ-023 Error and backpressure: r_resp=2 -> out_err=1, out_wen=0; out_ready held 0 for 4 cycles -> payload stable and in_ready=0 throughout.
REQ-024 Reset: assert rst_n=0 in RDATA -> next sampled state IDLE, all valids 0, in_ready=1.
